// File: rtl/neuron_pkg.sv
// Shared Q16.16 fixed-point types, saturation limits and arithmetic helpers
// for the learning neuron and its error source.
package neuron_pkg;

    localparam int Q_W       = 32;
    localparam int FRAC_BITS = 16;
    localparam int ACC_W     = Q_W + 8;

    typedef logic signed [Q_W-1:0]   q_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [2*Q_W-1:0] prod_t;

    localparam q_t SAT_MAX = 32'sh7FFF_FFFF;
    localparam q_t SAT_MIN = 32'sh8000_0000;

    // Clamp a wide accumulator back into the Q16.16 range.
    function automatic q_t sat_acc(acc_t v);
        q_t r;
        if (v > acc_t'(SAT_MAX))
            r = SAT_MAX;
        else if (v < acc_t'(SAT_MIN))
            r = SAT_MIN;
        else
            r = v[Q_W-1:0];
        return r;
    endfunction

    function automatic q_t mul(q_t a, q_t b);
        prod_t p;
        q_t    r;
        p = prod_t'(a) * prod_t'(b);
        p = p >>> FRAC_BITS;
        if (p > prod_t'(SAT_MAX))
            r = SAT_MAX;
        else if (p < prod_t'(SAT_MIN))
            r = SAT_MIN;
        else
            r = p[Q_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/learning_neuron_if.sv
// Data bundle between a neuron and whatever drives its synapses and learning terms.
interface learning_neuron_if #(
    parameter int N_IN = 32,
    parameter int W    = 32
);
    logic [N_IN-1:0][W-1:0] in;
    logic [N_IN-1:0]        enabled;
    logic signed [W-1:0]    backprop_in;
    logic signed [W-1:0]    rate;
    logic signed [W-1:0]    w_init;
    logic [N_IN-1:0][W-1:0] back;
    logic signed [W-1:0]    out;

    modport master (
        output in, enabled, backprop_in, rate, w_init,
        input  back, out
    );

    modport slave (
        input  in, enabled, backprop_in, rate, w_init,
        output back, out
    );
endinterface

// File: rtl/learning_neuron_backprop_start.sv
// Output-layer error source: delta = sat(expected - out), purely combinational.
module backprop_start
    import neuron_pkg::*;
(
    input  q_t expected,
    input  q_t out,
    output q_t delta
);
    assign delta = sat_acc(acc_t'(expected) - acc_t'(out));
endmodule

// File: rtl/learning_neuron.sv
// Linear neuron with per-synapse weights trained online by the delta rule.
// Data width W is expected to match the Q16.16 width of neuron_pkg.
module learning_neuron
    import neuron_pkg::*;
#(
    parameter int N_IN = 32,
    parameter int W    = 32
) (
    input logic              clk,
    input logic              rst,
    learning_neuron_if.slave bus
);

    q_t   prod   [N_IN];
    q_t   back_v [N_IN];
    q_t   out_q;
    acc_t acc;

    for (genvar i = 0; i < N_IN; i++) begin : g_syn
        q_t w_r;
        q_t inq_r;
        q_t grad;
        q_t w_next;

        // The gradient pairs this edge's delta with the inputs that produced the current out.
        assign grad   = mul(bus.rate, mul(bus.backprop_in, inq_r));
        assign w_next = sat_acc(acc_t'(w_r) + acc_t'(grad));

        assign prod[i]   = bus.enabled[i] ? mul($signed(bus.in[i]), w_r) : '0;
        assign back_v[i] = bus.enabled[i] ? mul(bus.backprop_in, w_r) : '0;

        always_ff @(posedge clk) begin
            if (rst) begin
                w_r   <= bus.w_init;
                inq_r <= '0;
            end else begin
                inq_r <= $signed(bus.in[i]);
                if (bus.enabled[i])
                    w_r <= w_next;
            end
        end
    end

    // Wide accumulation lets intermediate partial sums overshoot; only the total saturates.
    always_comb begin
        acc = '0;
        for (int i = 0; i < N_IN; i++)
            acc = acc + acc_t'(prod[i]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            out_q <= '0;
        else
            out_q <= sat_acc(acc);
    end

    always_comb begin
        bus.back = '0;
        for (int i = 0; i < N_IN; i++)
            bus.back[i] = back_v[i];
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_learning_neuron.sv
// Self-checking bench for learning_neuron fed by backprop_start: directed
// sequences, a vector table and a randomized run against an arithmetic model.
module tb_learning_neuron;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    learning_neuron_if #(.N_IN(N), .W(32)) bus ();

    int          tin [N];
    bit [N-1:0]  ten;
    int          tbp;
    int          trate;
    int          twinit;
    int          texp;
    bit          trst;
    bit          use_bp;
    logic [31:0] delta;

    longint mw [N];
    longint mq [N];
    longint mout;

    int checks = 0;
    int errors = 0;

    learning_neuron #(.N_IN(N), .W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    backprop_start u_bp (
        .expected (texp),
        .out      (bus.out),
        .delta    (delta)
    );

    assign bus.backprop_in = use_bp ? delta : tbp;

    function automatic longint clamp(longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic longint rmul(longint a, longint b);
        longint p;
        p = a * b;
        return clamp(p >>> 16);
    endfunction

    function automatic longint cur_bp();
        return use_bp ? clamp(longint'(texp) - mout) : longint'(tbp);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus();
        rst = trst;
        for (int i = 0; i < N; i++) bus.in[i] = tin[i];
        bus.enabled = ten;
        bus.rate    = trate;
        bus.w_init  = twinit;
        #1;
    endtask

    // Advance the model by one edge from its own state and the current inputs.
    task automatic model_edge();
        longint acc = 0;
        longint d;
        d = cur_bp();
        if (trst) begin
            for (int i = 0; i < N; i++) begin
                mw[i] = twinit;
                mq[i] = 0;
            end
            mout = 0;
            return;
        end
        for (int i = 0; i < N; i++)
            if (ten[i]) acc += rmul(tin[i], mw[i]);
        for (int i = 0; i < N; i++) begin
            if (ten[i]) mw[i] = clamp(mw[i] + rmul(trate, rmul(d, mq[i])));
            mq[i] = tin[i];
        end
        mout = clamp(acc);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("out", bus.out, 32'(mout));
    endtask

    task automatic check_output();
        for (int i = 0; i < N; i++)
            check($sformatf("back[%0d]", i), bus.back[i],
                  ten[i] ? 32'(rmul(cur_bp(), mw[i])) : 32'h0);
    endtask

    typedef struct {
        int       in0;
        int       in1;
        bit [1:0] en;
        int       exp_out;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{32'h0001_0000, 32'h0000_0000, 2'b11, 32'h0001_0000};
        tbl[1] = '{32'h0001_0000, 32'h0005_0000, 2'b01, 32'h0001_0000};
        tbl[2] = '{32'h0002_0000, 32'h0003_0000, 2'b11, 32'h0005_0000};
        tbl[3] = '{32'h7FFF_0000, 32'h7FFF_0000, 2'b11, 32'h7FFF_FFFF};
        tbl[4] = '{32'h8001_0000, 32'h8001_0000, 2'b11, 32'h8000_0000};
        tbl[5] = '{32'hFFFE_8000, 32'h0000_8000, 2'b11, 32'hFFFF_0000};
        tbl[6] = '{32'h0004_0000, 32'h0005_0000, 2'b00, 32'h0000_0000};

        for (int i = 0; i < N; i++) tin[i] = 0;
        ten = '0; tbp = 0; trate = 0; twinit = 32'h0001_0000;
        texp = 0; use_bp = 0; trst = 1;
        apply_stimulus();
        tick();
        check("reset_out", bus.out, 32'h0);

        // Basic forward pass with frozen weights.
        trst = 0;
        tin[0] = 32'h0001_0000; ten = 4'b0001;
        apply_stimulus();
        tick();
        check("setup_out", bus.out, 32'h0001_0000);
        tbp = 32'h0001_0000;
        apply_stimulus();
        check("setup_w0", bus.back[0], 32'h0001_0000);

        for (int v = 0; v < 7; v++) begin
            tin[0] = tbl[v].in0;
            tin[1] = tbl[v].in1;
            ten    = {2'b00, tbl[v].en};
            apply_stimulus();
            check_output();
            check($sformatf("tbl_back1[%0d]", v), bus.back[1],
                  tbl[v].en[1] ? 32'h0001_0000 : 32'h0);
            tick();
            check($sformatf("tbl_out[%0d]", v), bus.out, 32'(tbl[v].exp_out));
        end

        // Training toward 2.0 with a masked second synapse.
        for (int i = 0; i < N; i++) tin[i] = 0;
        tin[0] = 32'h0001_0000; tin[1] = 32'h0005_0000; ten = 4'b0001;
        trate = 32'h0000_8000; texp = 32'h0002_0000; use_bp = 1; trst = 1;
        apply_stimulus();
        tick();
        trst = 0;
        apply_stimulus();
        tick();
        check("learn_e1", bus.out, 32'h0001_0000);
        tick();
        check("learn_e2", bus.out, 32'h0001_0000);
        check("bp_back0", bus.back[0], 32'h0001_8000);
        check("mask_back1", bus.back[1], 32'h0);
        tick();
        check("learn_e3", bus.out, 32'h0001_8000);

        ten = 4'b0011; use_bp = 0; tbp = 32'h0001_0000;
        apply_stimulus();
        check("mask_w1", bus.back[1], 32'h0001_0000);
        ten = 4'b0001; use_bp = 1;
        apply_stimulus();

        tick();
        trst = 1;
        apply_stimulus();
        tick();
        check("midrst_out", bus.out, 32'h0);
        trst = 0;
        apply_stimulus();
        check("midrst_back0", bus.back[0], 32'h0002_0000);
        tick();
        check("post_rst_out", bus.out, 32'h0001_0000);

        // Randomized run against the model.
        twinit = int'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000;
        trst = 1;
        apply_stimulus();
        tick();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++)
                tin[i] = ($urandom_range(0, 15) == 0) ? int'($urandom)
                       : int'($urandom_range(0, 32'h0010_0000)) - 32'h0008_0000;
            ten    = N'($urandom);
            trate  = int'($urandom_range(0, 32'h0000_2000));
            tbp    = int'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000;
            texp   = int'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
            use_bp = $urandom_range(0, 1) == 1;
            trst   = $urandom_range(0, 49) == 0;
            apply_stimulus();
            check_output();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
